// File: rtl/prog_loader_pkg.sv
// Shared types and default build constants for the program loader.
// The state enum and the default widths/limits live here so every file agrees.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_XLEN       = 32;
  localparam int unsigned DEF_DEPTH      = 64;
  localparam int unsigned DEF_MAX_CYCLES = 1024;

endpackage

// File: rtl/prog_loader_if.sv
// Program-load handshake plus the instruction-memory write port.
// The loader is the slave of the load stream and drives the memory write.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = $clog2(DEF_DEPTH) + 2
) ();

  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic            ld_last;
  logic            ld_ready;
  logic            imem_we;
  logic [AW-1:0]   imem_addr;
  logic [XLEN-1:0] imem_wdata;

  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/prog_loader_run_watchdog.sv
// Run-phase cycle counter; expired flags the last permitted cycle.
// The count holds whenever enable is low, which freezes it once the run ends.
module run_watchdog
  import prog_loader_pkg::*;
#(
  parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  output logic [31:0] count,
  output logic        expired
);

  localparam logic [31:0] LIMIT = 32'(MAX_CYCLES - 1);

  logic [31:0] count_r;

  // Cycle counter: cleared by reset or clear, advanced only while enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= 32'd0;
    end else if (clear) begin
      count_r <= 32'd0;
    end else if (enable) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count   = count_r;
  assign expired = (count_r == LIMIT);

endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory while holding the core in reset,
// then releases the core and watches for it to run off the end or time out.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  prog_loader_if.slave    ld,
  input  logic [XLEN-1:0] core_pc,
  output logic            core_reset,
  output logic            done,
  output logic            timeout,
  output logic            overflow,
  output logic [31:0]     cycles
);

  localparam int AW = $clog2(DEPTH) + 2;
  localparam int IW = $clog2(DEPTH);
  localparam logic [AW-1:0] ADDR_STEP = AW'(4);
  localparam logic [AW:0]   END_STEP  = (AW + 1)'(4);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);

  state_t        state_r;
  logic [AW-1:0] addr_r;
  // One extra bit so a full DEPTH-word program still has a distinct end address.
  logic [AW:0]   end_addr_r;
  logic          ready_r;
  logic          core_reset_r;
  logic          done_r;
  logic          timeout_r;
  logic          overflow_r;

  logic          hs_s;
  logic          final_s;
  logic          pc_match_s;
  logic          wd_enable_s;
  logic          wd_clear_s;
  logic          wd_expired_s;
  logic [31:0]   wd_count_s;

  assign hs_s        = ld.ld_valid & ready_r & reset;
  assign final_s     = hs_s & (ld.ld_last | (addr_r[AW-1:2] == LAST_IDX));
  assign pc_match_s  = (state_r == RUN) && (core_pc == XLEN'(end_addr_r));
  assign wd_enable_s = (state_r == RUN) && !pc_match_s && !wd_expired_s;
  assign wd_clear_s  = (state_r == LOAD);

  run_watchdog #(
    .MAX_CYCLES (MAX_CYCLES)
  ) u_run_watchdog (
    .clk     (clk),
    .reset   (reset),
    .enable  (wd_enable_s),
    .clear   (wd_clear_s),
    .count   (wd_count_s),
    .expired (wd_expired_s)
  );

  // Loader FSM: LOAD writes words, RUN releases the core, DONE holds until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= LOAD;
      addr_r       <= '0;
      end_addr_r   <= '0;
      ready_r      <= 1'b1;
      core_reset_r <= 1'b1;
      done_r       <= 1'b0;
      timeout_r    <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          if (hs_s) begin
            addr_r <= addr_r + ADDR_STEP;
            if (final_s) begin
              end_addr_r   <= {1'b0, addr_r} + END_STEP;
              overflow_r   <= ~ld.ld_last;
              ready_r      <= 1'b0;
              core_reset_r <= 1'b0;
              state_r      <= RUN;
            end
          end
        end
        RUN: begin
          // A pc match wins over a simultaneous watchdog expiry.
          if (pc_match_s) begin
            done_r       <= 1'b1;
            core_reset_r <= 1'b1;
            state_r      <= DONE;
          end else if (wd_expired_s) begin
            done_r       <= 1'b1;
            timeout_r    <= 1'b1;
            core_reset_r <= 1'b1;
            state_r      <= DONE;
          end
        end
        DONE: begin
          state_r <= DONE;
        end
        default: begin
          state_r      <= LOAD;
          ready_r      <= 1'b1;
          core_reset_r <= 1'b1;
        end
      endcase
    end
  end

  assign ld.ld_ready   = ready_r;
  assign ld.imem_we    = hs_s;
  assign ld.imem_addr  = addr_r;
  assign ld.imem_wdata = ld.ld_data;

  assign core_reset = core_reset_r;
  assign done       = done_r;
  assign timeout    = timeout_r;
  assign overflow   = overflow_r;
  assign cycles     = wd_count_s;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a large and a small build share stimulus
// and are compared each cycle against a word-count/run-count model.
module tb_prog_loader;

  localparam int XLEN    = 32;
  localparam int B_DEPTH = 32;
  localparam int B_MAX   = 64;
  localparam int S_DEPTH = 4;
  localparam int S_MAX   = 16;
  localparam int B_AW    = $clog2(B_DEPTH) + 2;
  localparam int S_AW    = $clog2(S_DEPTH) + 2;

  logic        clk;
  logic        reset;
  logic        ld_valid;
  logic        ld_last;
  logic [31:0] ld_data;
  logic [31:0] core_pc;

  logic        b_core_reset, b_done, b_timeout, b_overflow;
  logic [31:0] b_cycles;
  logic        s_core_reset, s_done, s_timeout, s_overflow;
  logic [31:0] s_cycles;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model: index 0 = large build, 1 = small build
  int m_depth [2];
  int m_max   [2];
  int m_aw    [2];
  int m_n     [2];
  int m_cyc   [2];
  int m_end   [2];
  bit m_loaded[2];
  bit m_fin   [2];
  bit m_tmo   [2];
  bit m_ovf   [2];

  prog_loader_if #(.XLEN(XLEN), .AW(B_AW)) bif ();
  prog_loader_if #(.XLEN(XLEN), .AW(S_AW)) sif ();

  assign bif.ld_valid = ld_valid;
  assign bif.ld_data  = ld_data;
  assign bif.ld_last  = ld_last;
  assign sif.ld_valid = ld_valid;
  assign sif.ld_data  = ld_data;
  assign sif.ld_last  = ld_last;

  prog_loader #(.XLEN(XLEN), .DEPTH(B_DEPTH), .MAX_CYCLES(B_MAX)) u_big (
    .clk(clk), .reset(reset), .ld(bif), .core_pc(core_pc),
    .core_reset(b_core_reset), .done(b_done), .timeout(b_timeout),
    .overflow(b_overflow), .cycles(b_cycles)
  );

  prog_loader #(.XLEN(XLEN), .DEPTH(S_DEPTH), .MAX_CYCLES(S_MAX)) u_small (
    .clk(clk), .reset(reset), .ld(sif), .core_pc(core_pc),
    .core_reset(s_core_reset), .done(s_done), .timeout(s_timeout),
    .overflow(s_overflow), .cycles(s_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got 0x%0h expected 0x%0h", nm, m, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      m_n[m] = 0; m_cyc[m] = 0; m_end[m] = 0;
      m_loaded[m] = 1'b0; m_fin[m] = 1'b0; m_tmo[m] = 1'b0; m_ovf[m] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (!reset) begin
        m_n[m] = 0; m_cyc[m] = 0; m_end[m] = 0;
        m_loaded[m] = 1'b0; m_fin[m] = 1'b0; m_tmo[m] = 1'b0; m_ovf[m] = 1'b0;
      end else if (!m_loaded[m]) begin
        if (ld_valid) begin
          m_n[m]++;
          if (ld_last || m_n[m] == m_depth[m]) begin
            m_loaded[m] = 1'b1;
            m_end[m]    = 4 * m_n[m];
            m_ovf[m]    = (m_n[m] == m_depth[m]) && !ld_last;
          end
        end
      end else if (!m_fin[m]) begin
        if (core_pc == 32'(m_end[m])) begin
          m_fin[m] = 1'b1;
        end else if (m_cyc[m] == m_max[m] - 1) begin
          m_fin[m] = 1'b1;
          m_tmo[m] = 1'b1;
        end else begin
          m_cyc[m]++;
        end
      end
    end
  endtask

  task automatic check_dut(input int m, input logic rdy, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic cr, input logic dn,
                           input logic to, input logic ov, input logic [31:0] cy);
    logic exp_we;
    exp_we = reset && !m_loaded[m] && ld_valid;
    cmp("ld_ready",   m, 32'(rdy), 32'(!m_loaded[m]));
    cmp("imem_we",    m, 32'(we),  32'(exp_we));
    cmp("imem_addr",  m, addr,     32'((4 * m_n[m]) % (1 << m_aw[m])));
    if (exp_we) cmp("imem_wdata", m, wdata, ld_data);
    cmp("core_reset", m, 32'(cr),  32'(!(m_loaded[m] && !m_fin[m])));
    cmp("done",       m, 32'(dn),  32'(m_fin[m]));
    cmp("timeout",    m, 32'(to),  32'(m_tmo[m]));
    cmp("overflow",   m, 32'(ov),  32'(m_ovf[m]));
    cmp("cycles",     m, cy,       32'(m_cyc[m]));
  endtask

  // Every-cycle comparison of both builds against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, bif.ld_ready, bif.imem_we, 32'(bif.imem_addr), bif.imem_wdata,
                b_core_reset, b_done, b_timeout, b_overflow, b_cycles);
      check_dut(1, sif.ld_ready, sif.imem_we, 32'(sif.imem_addr), sif.imem_wdata,
                s_core_reset, s_done, s_timeout, s_overflow, s_cycles);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    core_pc  = 32'd0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
  endtask

  initial begin
    m_depth[0] = B_DEPTH; m_max[0] = B_MAX; m_aw[0] = B_AW;
    m_depth[1] = S_DEPTH; m_max[1] = S_MAX; m_aw[1] = S_AW;
    model_clear();
    reset = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'd0; core_pc = 32'd0;
    #2;
    reset = 1'b0;
    chk_en = 1'b1;

    // 28-word program; the small build overflows after 4 and times out meanwhile
    do_reset();
    for (int i = 0; i < 28; i++) begin
      ld_valid = 1'b1;
      ld_last  = (i == 27);
      ld_data  = (i == 0) ? 32'h123450b7 : (i == 27) ? 32'h00008a67 : $urandom;
      if (i == 27) begin
        #1;
        cmp("lit_last_addr", 0, 32'(bif.imem_addr), 32'd108);
        cmp("lit_last_we",   0, 32'(bif.imem_we), 32'd1);
      end
      if (i == 5) begin
        #1;
        cmp("lit_word6_not_written", 1, 32'(sif.imem_we), 32'd0);
      end
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    cmp("lit_core_reset_fall", 0, 32'(b_core_reset), 32'd0);
    cmp("lit_small_overflow",  1, 32'(s_overflow), 32'd1);
    cmp("lit_small_timeout",   1, 32'(s_timeout), 32'd1);
    cmp("lit_small_cycles",    1, s_cycles, 32'd15);
    core_pc = 32'd112;
    tick();
    cmp("lit_end112_done",   0, 32'(b_done), 32'd1);
    cmp("lit_end112_cycles", 0, b_cycles, 32'd0);
    tick();

    // 3-word program walked to its end
    do_reset();
    load_word($urandom, 1'b0);
    load_word($urandom, 1'b0);
    load_word($urandom, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      core_pc = 32'(4 * k);
      tick();
    end
    cmp("lit_pc_done",       0, 32'(b_done), 32'd1);
    cmp("lit_pc_cycles",     0, b_cycles, 32'd3);
    cmp("lit_pc_timeout",    0, 32'(b_timeout), 32'd0);
    cmp("lit_pc_core_reset", 0, 32'(b_core_reset), 32'd1);
    tick();

    // Long unterminated stream: overflow and watchdog expiry on both builds
    do_reset();
    for (int i = 0; i < 40; i++) load_word($urandom, 1'b0);
    ld_valid = 1'b0;
    for (int i = 0; i < 70; i++) tick();
    cmp("lit_big_overflow", 0, 32'(b_overflow), 32'd1);
    cmp("lit_big_timeout",  0, 32'(b_timeout), 32'd1);
    cmp("lit_big_cycles",   0, b_cycles, 32'd63);
    cmp("lit_s_cycles",     1, s_cycles, 32'd15);

    // Reset in the middle of RUN, then a fresh load
    do_reset();
    for (int i = 0; i < 5; i++) load_word($urandom, (i == 4));
    ld_valid = 1'b0; ld_last = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    cmp("lit_run5_cycles", 0, b_cycles, 32'd5);
    ld_valid = 1'b1;
    ld_data  = $urandom;
    reset    = 1'b0;
    model_clear();
    #1;
    cmp("lit_rst_ready",      0, 32'(bif.ld_ready), 32'd1);
    cmp("lit_rst_we",         0, 32'(bif.imem_we), 32'd0);
    cmp("lit_rst_core_reset", 0, 32'(b_core_reset), 32'd1);
    cmp("lit_rst_cycles",     0, b_cycles, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    cmp("lit_reload_addr", 0, 32'(bif.imem_addr), 32'd0);
    cmp("lit_reload_we",   0, 32'(bif.imem_we), 32'd1);
    tick();
    ld_valid = 1'b0;
    tick();

    // Random programs: gapped handshakes, assorted pc behaviour, occasional reset
    for (int p = 0; p < 24; p++) begin
      int nword;
      int vmode;
      int pmode;
      int w;
      int k;
      bit use_last;
      logic [31:0] pcv;
      do_reset();
      nword    = $urandom_range(1, 40);
      use_last = ($urandom_range(0, 3) != 0);
      vmode    = $urandom_range(0, 2);
      pmode    = $urandom_range(0, 2);
      w = 0;
      k = 0;
      while (w < nword) begin
        ld_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(k % 2 == 0) : 1'($urandom_range(0, 1));
        ld_data  = $urandom;
        ld_last  = use_last && (w == nword - 1);
        core_pc  = 32'($urandom_range(0, 45) * 4);
        tick();
        if (ld_valid) w++;
        k++;
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      pcv = 32'd0;
      for (int c = 0; c < 90; c++) begin
        if (pmode == 0) begin
          core_pc = pcv;
          if ($urandom_range(0, 3) != 0) pcv = pcv + 32'd4;
        end else if (pmode == 1) begin
          core_pc = 32'($urandom_range(0, 45) * 4);
        end else begin
          core_pc = 32'd0;
        end
        ld_valid = 1'($urandom_range(0, 1));
        ld_data  = $urandom;
        ld_last  = 1'($urandom_range(0, 1));
        if ((p % 6 == 5) && (c == 7)) begin
          reset = 1'b0;
          model_clear();
          tick();
          reset = 1'b1;
        end else begin
          tick();
        end
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
- REQ-001: Parameter XLEN, default 32: instruction and PC width in bits.
- REQ-002: Parameter DEPTH, default 64: maximum program length in words.
- REQ-003: Parameter MAX_CYCLES, default 1024: run-phase watchdog limit in clock cycles.
- REQ-004: Derived constant AW = clog2(DEPTH)+2: byte-address width.
- REQ-005: clk  in  1  single system clock; all state updates on its rising edge.
- REQ-006: reset  in  1  asynchronous, active-low reset (0 = reset).
- REQ-007: ld_valid  in  1  a program word is offered.
- REQ-008: ld_data  in  XLEN  the offered instruction word.
- REQ-009: ld_last  in  1  the offered word is the final one of the program.
- REQ-010: ld_ready  out  1  the loader accepts a word this cycle.
- REQ-011: imem_we  out  1  instruction-memory write strobe.
- REQ-012: imem_addr  out  AW  byte address of the write (word-aligned, step 4).
- REQ-013: imem_wdata  out  XLEN  write data.
- REQ-014: core_pc  in  XLEN  current PC of the attached core.
- REQ-015: core_reset  out  1  active-high hold-reset to the core.
- REQ-016: done  out  1  run finished (sticky).
- REQ-017: timeout  out  1  run ended by the watchdog (sticky).
- REQ-018: overflow  out  1  more than DEPTH words were offered (sticky).
- REQ-019: cycles  out  32  run-phase cycle count, frozen at done.

Function
- REQ-020: The FSM SHALL have states LOAD, RUN and DONE, and SHALL enter LOAD on reset.
- REQ-021: LOAD: ld_ready=1, core_reset=1; a handshake (ld_valid&&ld_ready) SHALL assert imem_we combinationally in that cycle, with imem_wdata=ld_data.
- REQ-022: imem_addr SHALL start at 0 and increment by 4 after every accepted word; end_addr SHALL hold the byte address after the last accepted word.
- REQ-023: LOAD->RUN SHALL occur on a handshake with ld_last=1, or on acceptance of word DEPTH-1; the final word is written in that same cycle.
- REQ-024: Reaching DEPTH words without ld_last SHALL set overflow, unless ld_last arrives on that same word (then overflow stays 0).
- REQ-025: In RUN and DONE, ld_ready SHALL be 0 and imem_we SHALL be 0; offered words are ignored.
- REQ-026: RUN: core_reset SHALL be 0 starting the first cycle after the final write; cycles SHALL increment once per RUN cycle, starting from 0.
- REQ-027: RUN->DONE SHALL occur when core_pc equals end_addr (the program has run off its end), or when cycles reaches MAX_CYCLES-1 (this sets timeout).
- REQ-028: If both RUN->DONE conditions are true in the same cycle, the core_pc match SHALL take priority and timeout SHALL stay 0.
- REQ-029: DONE: core_reset=1, done=1, cycles frozen; DONE SHALL be left only by reset.
- REQ-030: A program with zero words is impossible; the first accepted word is always written.

Reset
- REQ-031: Asserting reset at any time, including mid-LOAD or mid-RUN, SHALL immediately produce state=LOAD, imem_addr=0, end_addr=0, cycles=0, and done=timeout=overflow=0.
- REQ-032: While reset is asserted, ld_ready=1, imem_we=0 and core_reset=1; the reset release needs no synchronizer inside this block.

Structure
- REQ-033: Package prog_loader_pkg SHALL hold the state enum (LOAD, RUN, DONE) and the default XLEN/DEPTH/MAX_CYCLES constants.
- REQ-034: The watchdog SHALL be one sub-module, run_watchdog (enable, clear, count, expired); everything else SHALL be flat.

Verification
- REQ-035: Load 28 words (0x123450b7 ... 0x00008a67) with ld_last on the 28th -> writes to addresses 0..108 step 4; end_addr=112; core_reset falls one cycle later.
- REQ-036: After a 3-word load, drive core_pc = 0, 4, 8, 12 on successive RUN cycles -> DONE on the cycle with pc=12; cycles=3; timeout=0; core_reset=1.
- REQ-037: DEPTH=4 build, offer 6 words with no ld_last -> 4 writes, overflow=1, RUN entered, words 5 and 6 are not written.
- REQ-038: MAX_CYCLES=16, core_pc held at 0 -> DONE with timeout=1 and cycles=15.
- REQ-039: Assert reset at RUN cycle 5 -> all outputs return to their reset values at once; a fresh load then restarts at imem_addr=0.
- REQ-040: Toggle ld_valid on alternate cycles during LOAD -> only handshake cycles write; addresses stay contiguous.
